ram_sp_pipe: RTL

- Parametrised single-port synchronous SRAM model; next generation of the project's RAM_S-style buffers used by the OMP datapath (residual, index and coefficient stores).
- Adds over the current buffers: chip select, per-lane byte write enables, configurable read latency, selectable read-during-write mode, read-valid strobe, out-of-range protection and a post-reset zero-fill engine.
- Keeps the output-enable tri-state Q behaviour so it drops into the existing shared-bus testbenches.

---
 rtl/ram_sp_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_sp_pipe.sv
// Single-port synchronous SRAM with lane write enables, a configurable read pipeline,
// selectable read-during-write data, out-of-range protection and a post-reset zero-fill engine.
module ram_sp_pipe #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 256,
  parameter int LANES        = 4,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  CK,
  input  logic                  RST_N,
  input  logic                  CS,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  WE,
  input  logic [LANES-1:0]      BE,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  OE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QV,
  output logic                  BUSY
);

  localparam int LW    = DATA_WIDTH / LANES;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;

  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

  logic                    in_range;
  logic                    access;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_new;
  logic                    acc_valid;
  logic [DATA_WIDTH-1:0]   acc_data;

  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [LANES-1:0]        wr_lanes;

  logic [DATA_WIDTH-1:0]   pipe_data [RD_LAT];
  logic [RD_LAT-1:0]       pipe_vld;

  // Clear engine state
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_WIDTH'(MEM_SIZE - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign BUSY = (state == ST_CLEAR);

  // Extra top bit keeps the compare exact when MEM_SIZE == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, A} < (ADDR_WIDTH + 1)'(MEM_SIZE));
  assign access   = (state == ST_IDLE) && CS;
  assign wr_en    = access && WE && in_range;

  // Out-of-range accesses report zero, including the write-cycle read data.
  always_comb begin
    rd_old = '0;
    if (in_range) begin
      rd_old = mem[A[IDX_W-1:0]];
    end
    rd_new = rd_old;
    for (int i = 0; i < LANES; i++) begin
      if (BE[i]) begin
        rd_new[i*LW +: LW] = D[i*LW +: LW];
      end
    end
    if (!in_range) begin
      rd_new = '0;
    end
    acc_valid = access && (!WE || (RDW_MODE != 0));
    acc_data  = (WE && (RDW_MODE == 2)) ? rd_new : rd_old;
  end

  // The zero-fill engine and normal writes share the single write port.
  always_comb begin
    wr_idx   = A[IDX_W-1:0];
    wr_data  = D;
    wr_lanes = wr_en ? BE : '0;
    if (state == ST_CLEAR) begin
      wr_idx   = clr_cnt[IDX_W-1:0];
      wr_data  = '0;
      wr_lanes = '1;
    end
  end

  always_ff @(posedge CK) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_idx][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  // Stage 0 is the array output register; the last stage is the visible data register.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data[i] <= '0;
      end
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= acc_valid;
      if (acc_valid) begin
        pipe_data[0] <= acc_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign QV = pipe_vld[RD_LAT-1];
  assign Q  = OE ? pipe_data[RD_LAT-1] : {DATA_WIDTH{1'bz}};

endmodule
